// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage pending-write scoreboard for long-latency producers (loads, MUL/DIV).
// Optional macro SCOREBOARD_WB_BYPASS_EN: a same-cycle writeback releases waiting consumers immediately.
module hazard_scoreboard #(
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_long,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush_ex,
    input  logic             flush_ex_long,
    input  logic [4:0]       flush_ex_rd,
    output logic             stall,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             busy,
    output logic             err
);

    logic [31:0]      pending;
    logic [CNT_W-1:0] cnt;
    logic             errFlag;

    logic [31:0] hazardView;
    logic [31:0] setMask;
    logic [31:0] clrMask;
    logic [31:0] pendingNext;
    logic        raw1, raw2, waw, full;
    logic        rdNonZero, issue;
    logic        clearWb, clearFl, wbHit, flCounted;
    logic        overflow, errEvent;
    int          nextCntInt;

    function automatic logic [CNT_W-1:0] satCount(input int value);
        if (value > MAX_PENDING) return CNT_W'(MAX_PENDING);
        if (value < 0)           return '0;
        return CNT_W'(value);
    endfunction

    assign clearWb = wb_valid & (wb_rd != 5'd0);
    assign clearFl = flush_ex & flush_ex_long & (flush_ex_rd != 5'd0);

`ifdef SCOREBOARD_WB_BYPASS_EN
    // Register file writes through, so a register retiring this cycle is readable now.
    assign hazardView = pending & ~(clearWb ? (32'd1 << wb_rd) : 32'd0);
`else
    assign hazardView = pending;
`endif

    assign rdNonZero = id_rd != 5'd0;
    assign raw1  = id_uses_rs1 & hazardView[id_rs1] & (id_rs1 != 5'd0);
    assign raw2  = id_uses_rs2 & hazardView[id_rs2] & (id_rs2 != 5'd0);
    assign waw   = id_regwrite & rdNonZero & hazardView[id_rd];
    assign full  = id_long & id_regwrite & rdNonZero & (cnt == CNT_W'(MAX_PENDING));
    assign stall = ~rst & id_valid & (raw1 | raw2 | waw | full);
    assign issue = id_valid & ~stall & id_long & id_regwrite & rdNonZero;

    // A writeback and a flush naming the same register retire one entry, not two.
    assign wbHit     = clearWb & pending[wb_rd];
    assign flCounted = clearFl & pending[flush_ex_rd] & ~(clearWb & (wb_rd == flush_ex_rd));

    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (issue)   setMask[id_rd]       = 1'b1;
        if (clearWb) clrMask[wb_rd]       = 1'b1;
        if (clearFl) clrMask[flush_ex_rd] = 1'b1;
        pendingNext = ((pending & ~clrMask) | setMask) & ~32'd1;
        nextCntInt  = int'(cnt) + int'(issue) - int'(wbHit) - int'(flCounted);
        overflow    = nextCntInt > MAX_PENDING;
        errEvent    = (clearWb & ~pending[wb_rd]) | (clearFl & ~pending[flush_ex_rd]) | overflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            cnt     <= '0;
            errFlag <= 1'b0;
        end else begin
            pending <= pendingNext;
            cnt     <= satCount(nextCntInt);
            errFlag <= errFlag | errEvent;
        end
    end

    assign pending_cnt = cnt;
    assign busy        = cnt != '0;
    assign err         = errFlag;

endmodule
